// File: rtl/uart_pkt_tx_pkg.sv
// Shared definitions for the miner->host packet framer: sync byte, frame type codes
// and the framer state encoding.
`default_nettype none

package uart_pkt_tx_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam logic [7:0] PKT_NONCE  = 8'h01;
  localparam logic [7:0] PKT_STATUS = 8'h02;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DONE = 2'd2,
    FINISH    = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_pkt_tx.sv
// Packet framer: turns one result word plus type code into SYNC, TYPE, payload (LSB first),
// XOR checksum, handed byte by byte to the UART transmitter over its DV/Active/Done handshake.
`default_nettype none

module uart_pkt_tx
  import uart_pkt_tx_pkg::*;
#(
  parameter int          PAYLOAD_BYTES = 8,
  parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEF
) (
  input  logic                         i_Clock,
  input  logic                         i_n_Reset,
  input  logic                         i_Pkt_Valid,
  output logic                         o_Pkt_Ready,
  input  logic [7:0]                   i_Pkt_Type,
  input  logic [8*PAYLOAD_BYTES-1:0]   i_Pkt_Data,
  output logic                         o_Tx_DV,
  output logic [7:0]                   o_Tx_Byte,
  input  logic                         i_Tx_Active,
  input  logic                         i_Tx_Done,
  output logic                         o_Busy,
  output logic                         o_Pkt_Sent
);

  localparam int IDX_W = $clog2(PAYLOAD_BYTES + 3);
  localparam int SEL_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES + 2);

  state_t                       state;
  state_t                       state_nxt;
  logic [IDX_W-1:0]             idx;
  logic [IDX_W-1:0]             idx_nxt;
  logic [SEL_W-1:0]             sel;
  logic [7:0]                   type_q;
  logic [7:0]                   cksum;
  logic [7:0]                   tx_byte;
  logic [7:0]                   next_byte;
  logic [8*PAYLOAD_BYTES-1:0]   data_q;
  logic                         accept;
  logic                         load_next;

  assign accept    = i_Pkt_Valid && (state == IDLE);
  assign load_next = (state == WAIT_DONE) && i_Tx_Done && (idx != LAST_IDX);
  assign idx_nxt   = idx + IDX_W'(1);
  // Frame positions 2..N+1 carry the payload, so the byte select is offset by two.
  assign sel       = SEL_W'(idx_nxt - IDX_W'(2));

  always_comb begin
    next_byte = cksum;
    if (idx_nxt == IDX_W'(1)) begin
      next_byte = type_q;
    end else if (idx_nxt != LAST_IDX) begin
      next_byte = data_q[{sel, 3'b000} +: 8];
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_n_Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (i_Pkt_Valid) state_nxt = REQ;
      // DV stays asserted until the transmitter shows Active; a late Done is not looked at here.
      REQ:       if (i_Tx_Active) state_nxt = WAIT_DONE;
      WAIT_DONE: if (i_Tx_Done)   state_nxt = (idx == LAST_IDX) ? FINISH : REQ;
      FINISH:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_n_Reset) begin
      type_q  <= 8'h00;
      data_q  <= '0;
      cksum   <= 8'h00;
      idx     <= '0;
      tx_byte <= 8'h00;
    end else if (accept) begin
      type_q  <= i_Pkt_Type;
      data_q  <= i_Pkt_Data;
      cksum   <= 8'h00;
      idx     <= '0;
      tx_byte <= SYNC_BYTE;
    end else if (load_next) begin
      idx     <= idx_nxt;
      tx_byte <= next_byte;
      if (idx_nxt != LAST_IDX) begin
        cksum <= cksum ^ next_byte;
      end
    end
  end

  assign o_Pkt_Ready = (state == IDLE);
  assign o_Tx_DV     = (state == REQ);
  assign o_Tx_Byte   = tx_byte;
  assign o_Busy      = (state != IDLE);
  assign o_Pkt_Sent  = (state == FINISH);

endmodule

`default_nettype wire
